pulse_readout_ctrl: RTL and testbench
=====================================

// Module: pulse_readout_ctrl
// PURPOSE
//  Run controller and event buffer for the pulse integrator (adc/discriminator/halt -> 64-bit count + ready).
//  Drives the integrator's discriminator and halt inputs, captures each completed pulse word into a FIFO,
//  and presents the words to the host through a valid/ready stream. Applies back-pressure through halt
//  before the FIFO overflows, and keeps event and drop statistics.
// PARAMETERS
//  FIFO_AW     4   log2 FIFO depth (DEPTH = 16)
//  HALT_MARGIN 2   halt asserted in RUN when free FIFO entries <= HALT_MARGIN
//  ARM_CYCLES  4   settle cycles in ARM before releasing halt
// PORTS
//  clk           in   1   single system clock; all logic on posedge
//  rst_n         in   1   one clock; reset is synchronous and active-low
//  cmd_start     in   1   1-cycle pulse: start acquisition
//  cmd_stop      in   1   1-cycle pulse: stop acquisition
//  cfg_threshold in   8   discriminator value, latched on accepted cmd_start
//  pulse_ready   in   1   integrator ready (1 cycle per completed pulse)
//  pulse_word    in   64  integrator count: [31:0] integral, [55:32] length, [63:56] peak
//  disc          out  8   to integrator discriminator
//  halt          out  1   to integrator halt
//  run           out  1   high in ARM or RUN
//  rd_valid      out  1   rd_data holds a buffered word
//  rd_ready      in   1   host accepts word when rd_valid & rd_ready
//  rd_data       out  64  oldest buffered pulse word
//  fifo_level    out  FIFO_AW+1  words held
//  event_cnt     out  32  pulses stored since start, wraps at 2^32
//  drop_cnt      out  16  pulses lost to full FIFO since start, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, disc=0, halt=1, run=0, rd_valid=0, rd_data=0, fifo_level=0,
//   event_cnt=0, drop_cnt=0; FIFO emptied. Reset mid-run discards buffered words.
//  FSM: IDLE -> ARM on cmd_start (latch disc<=cfg_threshold; clear event_cnt, drop_cnt; FIFO contents kept).
//   ARM: halt=1, count ARM_CYCLES cycles -> RUN. cmd_stop in ARM -> DRAIN.
//   RUN: halt = (DEPTH - fifo_level) <= HALT_MARGIN; cmd_stop -> DRAIN.
//   DRAIN: halt=1; -> IDLE the cycle after fifo_level reaches 0. IDLE/DRAIN: halt=1.
//   cmd_start outside IDLE ignored; cmd_start and cmd_stop in same cycle: stop wins (IDLE stays IDLE).
//  Capture: pulse_ready=1 in any state except IDLE -> push pulse_word; pulse_ready in IDLE ignored.
//   Push accepted if fifo_level<DEPTH, or fifo_level==DEPTH with a pop in the same cycle;
//   accepted push: event_cnt+1. Rejected push: drop_cnt+1 (saturating), word lost.
//  FIFO: first-word-fall-through; word pushed in cycle N shows on rd_data/rd_valid at N+1.
//   Pop when rd_valid & rd_ready; rd_data/rd_valid registered. Simultaneous push+pop: level unchanged.
//   rd_data holds value while rd_valid & ~rd_ready.
//  Halt latency: halt is registered; the integrator may complete one pulse after halt rises,
//   hence HALT_MARGIN >= 1; HALT_MARGIN=0 is illegal.
// CONFIGURATION
//  PULSE_PEAK_FILTER_EN defined: extra input cfg_peak_min[7:0] (latched with cfg_threshold);
//   a captured word with pulse_word[63:56] < cfg_peak_min is discarded without counting in event_cnt
//   or drop_cnt; extra output reject_cnt[15:0], saturating, cleared on start and reset.
//  Undefined: port and counter absent; every captured word goes to the FIFO push path.
// STRUCTURE
//  pulse_ctrl_pkg: state enum {IDLE, ARM, RUN, DRAIN}; field constants INTEG_LSB=0, INTEG_W=32,
//   LEN_LSB=32, LEN_W=24, PEAK_LSB=56, PEAK_W=8; PULSE_W=64.
//  Sub-module pulse_event_fifo: sync FWFT FIFO (WIDTH=64, AW=FIFO_AW) with push/pop/level/full/empty.
//   The FSM, halt logic and counters stay in pulse_readout_ctrl.
// TESTING
//  Start with cfg_threshold=8'h20 -> disc=8'h20, halt falls exactly ARM_CYCLES+1 cycles after cmd_start.
//  3 pulses, rd_ready=1 -> 3 words out in order, each 1 cycle after its pulse_ready; event_cnt=3.
//  rd_ready=0, 20 pulses -> halt=1 when level>=14; level stops at 16, drop_cnt=4, event_cnt=16.
//  Level 16 + pulse_ready with rd_ready=1 same cycle -> push accepted, level 16, drop_cnt unchanged.
//  cmd_stop with 5 words buffered -> halt=1, drains 5 words, IDLE 1 cycle after level 0; start+stop same cycle in IDLE -> stays IDLE.
//  rst_n=0 mid-RUN with 7 words -> next cycle all outputs at reset values, level 0; PEAK_FILTER: peak 8'h10, min 8'h40 -> reject_cnt=1.

Source files
------------

// File: rtl/pulse_readout_ctrl_pkg.sv
// Shared types and pulse-word field layout for the pulse readout controller.
// Pure declarations: no latency, no flow control.
package pulse_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int PULSE_W   = 64;
    localparam int INTEG_LSB = 0;
    localparam int INTEG_W   = 32;
    localparam int LEN_LSB   = 32;
    localparam int LEN_W     = 24;
    localparam int PEAK_LSB  = 56;
    localparam int PEAK_W    = 8;

    typedef struct packed {
        logic [PEAK_W-1:0]  peak;
        logic [LEN_W-1:0]   len;
        logic [INTEG_W-1:0] integ;
    } pulse_t;

    function automatic logic [PEAK_W-1:0] pulse_peak(input logic [PULSE_W-1:0] w);
        return w[PEAK_LSB +: PEAK_W];
    endfunction

endpackage

// File: rtl/pulse_readout_ctrl_if.sv
// Host read stream: oldest buffered pulse word with valid/ready handshake.
// Word transfers on a cycle where rd_valid and rd_ready are both high.
interface pulse_readout_ctrl_if;
    import pulse_ctrl_pkg::*;

    logic               rd_valid;
    logic               rd_ready;
    logic [PULSE_W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);

endinterface

// File: rtl/pulse_event_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head word and level.
// Push shows on rd_data one cycle later; push while full is accepted only alongside a pop.
module pulse_event_fifo #(
    parameter int WIDTH = 64,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      level,
    output logic [AW:0]      level_nxt,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [AW:0]      level_after_pop;
    logic             pop;
    logic             push_ok;

    assign full            = (level == (AW+1)'(DEPTH));
    assign empty           = (level == '0);
    assign pop             = rd_valid & rd_ready;
    assign push_ok         = push & (~full | pop);
    assign rd_ptr_nxt      = rd_ptr + AW'(pop);
    assign level_after_pop = level - (AW+1)'(pop);
    assign level_nxt       = level_after_pop + (AW+1)'(push_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // A word landing in an otherwise-empty FIFO bypasses the array so it is visible next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr   <= rd_ptr_nxt;
            level    <= level_nxt;
            rd_valid <= (level_nxt != '0);
            if (push_ok && (level_after_pop == '0)) begin
                rd_data <= push_data;
            end else begin
                rd_data <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/pulse_readout_ctrl.sv
// Run control + event buffer for the pulse integrator; optional peak filter via PULSE_PEAK_FILTER_EN.
// Words appear on rd one cycle after pulse_ready; halt is registered, raised when FIFO free space <= HALT_MARGIN.
module pulse_readout_ctrl
    import pulse_ctrl_pkg::*;
#(
    parameter int FIFO_AW     = 4,
    parameter int HALT_MARGIN = 2,
    parameter int ARM_CYCLES  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_start,
    input  logic                 cmd_stop,
    input  logic [7:0]           cfg_threshold,
`ifdef PULSE_PEAK_FILTER_EN
    input  logic [7:0]           cfg_peak_min,
`endif
    input  logic                 pulse_ready,
    input  logic [PULSE_W-1:0]   pulse_word,
    output logic [7:0]           disc,
    output logic                 halt,
    output logic                 run,
    pulse_readout_ctrl_if.master rd,
    output logic [FIFO_AW:0]     fifo_level,
    output logic [31:0]          event_cnt,
`ifdef PULSE_PEAK_FILTER_EN
    output logic [15:0]          reject_cnt,
`endif
    output logic [15:0]          drop_cnt
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int ACW   = ($clog2(ARM_CYCLES + 1) < 1) ? 1 : $clog2(ARM_CYCLES + 1);

    state_t           state;
    logic [ACW-1:0]   arm_cnt;
    logic [FIFO_AW:0] level_nxt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             capture_raw;
    logic             capture;
    logic             pop;
    logic             accepted;
    logic             dropped;
    logic             start_acc;
    logic             near_full_nxt;

    assign start_acc   = (state == IDLE) & cmd_start & ~cmd_stop;
    assign capture_raw = pulse_ready & (state != IDLE);
    assign pop         = rd.rd_valid & rd.rd_ready;
    assign accepted    = capture & (~fifo_full | pop);
    assign dropped     = capture & ~accepted;

    // Looking at next-cycle occupancy keeps halt aligned with the fifo_level it reflects.
    assign near_full_nxt = (DEPTH - int'(level_nxt)) <= HALT_MARGIN;

`ifdef PULSE_PEAK_FILTER_EN
    logic [7:0] peak_min_q;
    logic       peak_ok;

    assign peak_ok = (pulse_peak(pulse_word) >= peak_min_q);
    assign capture = capture_raw & peak_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_min_q <= '0;
            reject_cnt <= '0;
        end else if (start_acc) begin
            peak_min_q <= cfg_peak_min;
            reject_cnt <= '0;
        end else if (capture_raw && !peak_ok && (reject_cnt != 16'hFFFF)) begin
            reject_cnt <= reject_cnt + 16'd1;
        end
    end
`else
    assign capture = capture_raw;
`endif

    pulse_event_fifo #(
        .WIDTH (PULSE_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data (pulse_word),
        .rd_ready  (rd.rd_ready),
        .rd_valid  (rd.rd_valid),
        .rd_data   (rd.rd_data),
        .level     (fifo_level),
        .level_nxt (level_nxt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // HALT_MARGIN must be >= 1: the integrator can finish one more pulse after halt rises.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            arm_cnt   <= '0;
            disc      <= '0;
            halt      <= 1'b1;
            run       <= 1'b0;
            event_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    halt <= 1'b1;
                    if (start_acc) begin
                        state   <= ARM;
                        arm_cnt <= '0;
                        disc    <= cfg_threshold;
                        run     <= 1'b1;
                    end
                end
                ARM: begin
                    halt <= 1'b1;
                    if (cmd_stop) begin
                        state <= DRAIN;
                        run   <= 1'b0;
                    end else if (arm_cnt == ACW'(ARM_CYCLES)) begin
                        state <= RUN;
                        halt  <= near_full_nxt;
                    end else begin
                        arm_cnt <= arm_cnt + ACW'(1);
                    end
                end
                RUN: begin
                    if (cmd_stop) begin
                        state <= DRAIN;
                        halt  <= 1'b1;
                        run   <= 1'b0;
                    end else begin
                        halt <= near_full_nxt;
                    end
                end
                DRAIN: begin
                    halt <= 1'b1;
                    if (fifo_empty) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    halt  <= 1'b1;
                    run   <= 1'b0;
                end
            endcase

            if (start_acc) begin
                event_cnt <= '0;
                drop_cnt  <= '0;
            end else begin
                if (accepted) begin
                    event_cnt <= event_cnt + 32'd1;
                end
                if (dropped && (drop_cnt != 16'hFFFF)) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_readout_ctrl.sv
// Directed bench for pulse_readout_ctrl; expected read words queued at stimulus, compared by a monitor.
module tb_pulse_readout_ctrl;
    import pulse_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_start;
    logic        cmd_stop;
    logic [7:0]  cfg_threshold;
    logic        pulse_ready;
    logic [63:0] pulse_word;
    logic [7:0]  disc;
    logic        halt;
    logic        run;
    logic [4:0]  fifo_level;
    logic [31:0] event_cnt;
    logic [15:0] drop_cnt;
`ifdef PULSE_PEAK_FILTER_EN
    logic [7:0]  cfg_peak_min;
    logic [15:0] reject_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    pulse_readout_ctrl_if rd_if ();

    pulse_readout_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_start     (cmd_start),
        .cmd_stop      (cmd_stop),
        .cfg_threshold (cfg_threshold),
`ifdef PULSE_PEAK_FILTER_EN
        .cfg_peak_min  (cfg_peak_min),
        .reject_cnt    (reject_cnt),
`endif
        .pulse_ready   (pulse_ready),
        .pulse_word    (pulse_word),
        .disc          (disc),
        .halt          (halt),
        .run           (run),
        .rd            (rd_if),
        .fifo_level    (fifo_level),
        .event_cnt     (event_cnt),
        .drop_cnt      (drop_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk(input logic [7:0] peak, input int i);
        return {peak, 24'(i * 3 + 1), 32'hA500_0000 + 32'(i)};
    endfunction

    task automatic pulse(input logic [63:0] w, input bit stored);
        pulse_ready = 1'b1;
        pulse_word  = w;
        if (stored) exp_q.push_back(w);
        tick();
        pulse_ready = 1'b0;
    endtask

    task automatic start(input logic [7:0] thr);
        cfg_threshold = thr;
        cmd_start     = 1'b1;
        tick();
        cmd_start     = 1'b0;
    endtask

    task automatic wait_halt_low(output int n);
        n = 0;
        while (halt && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Scoreboard monitor: every handshake must deliver the oldest expected word.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rd_if.rd_valid === 1'b1 && rd_if.rd_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_data: got %0h expected no word", rd_if.rd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", rd_if.rd_data, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int lv;
        rst_n          = 1'b0;
        cmd_start      = 1'b0;
        cmd_stop       = 1'b0;
        cfg_threshold  = 8'h00;
        pulse_ready    = 1'b0;
        pulse_word     = '0;
        rd_if.rd_ready = 1'b0;
`ifdef PULSE_PEAK_FILTER_EN
        cfg_peak_min   = 8'h00;
`endif
        tick();
        tick();
        chk("rst_disc", disc, 0);
        chk("rst_halt", halt, 1);
        chk("rst_run", run, 0);
        chk("rst_rd_valid", rd_if.rd_valid, 0);
        chk("rst_rd_data", rd_if.rd_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_event", event_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Start: disc latched, halt released ARM_CYCLES+1 cycles after cmd_start.
        start(8'h20);
        chk("start_disc", disc, 8'h20);
        chk("start_run", run, 1);
        chk("arm_halt", halt, 1);
        wait_halt_low(n);
        chk("halt_release_cycles", n, 5);

        // Three pulses streamed straight through.
        rd_if.rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse(mk(8'h80, i), 1'b1);
            chk("fwft_valid", rd_if.rd_valid, 1);
            chk("fwft_data", rd_if.rd_data, mk(8'h80, i));
        end
        tick();
        chk("stream_event", event_cnt, 3);
        chk("stream_level", fifo_level, 0);

        // Fill with host stalled: halt at level >= 14, overflow drops four.
        rd_if.rd_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            pulse(mk(8'h90, 100 + k), k <= 16);
            lv = (k < 16) ? k : 16;
            chk("fill_level", fifo_level, lv);
            chk("fill_halt", halt, lv >= 14);
        end
        chk("fill_drop", drop_cnt, 4);
        chk("fill_event", event_cnt, 19);

        // Full FIFO with simultaneous pop: push accepted, no drop.
        rd_if.rd_ready = 1'b1;
        pulse(mk(8'hA0, 200), 1'b1);
        chk("full_pop_level", fifo_level, 16);
        chk("full_pop_drop", drop_cnt, 4);
        chk("full_pop_event", event_cnt, 20);
        chk("full_pop_halt", halt, 1);

        repeat (11) tick();
        rd_if.rd_ready = 1'b0;
        chk("drain11_level", fifo_level, 5);
        chk("drain11_halt", halt, 0);

        // Stop with five buffered: drain, then IDLE one cycle after level 0.
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        chk("stop_halt", halt, 1);
        chk("stop_run", run, 0);
        chk("stop_level", fifo_level, 5);
        rd_if.rd_ready = 1'b1;
        n = 0;
        while (fifo_level != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_cycles", n, 5);
        pulse(mk(8'hB0, 300), 1'b1);
        chk("drain_last_capture", event_cnt, 21);
        chk("drain_last_valid", rd_if.rd_valid, 1);
        pulse(mk(8'hB0, 301), 1'b0);
        chk("idle_ignore_event", event_cnt, 21);
        chk("idle_ignore_level", fifo_level, 0);
        rd_if.rd_ready = 1'b0;

        // Start and stop together in IDLE: nothing happens.
        cfg_threshold = 8'h55;
        cmd_start     = 1'b1;
        cmd_stop      = 1'b1;
        tick();
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        chk("startstop_run", run, 0);
        chk("startstop_disc", disc, 8'h20);
        tick();
        tick();
        chk("startstop_run_later", run, 0);

        // Restart clears counters; reset mid-run with seven buffered.
        start(8'h33);
        chk("restart_disc", disc, 8'h33);
        chk("restart_run", run, 1);
        chk("restart_event", event_cnt, 0);
        chk("restart_drop", drop_cnt, 0);
        wait_halt_low(n);
        chk("restart_halt_cycles", n, 5);
        for (int i = 0; i < 7; i++) pulse(mk(8'hC0, 400 + i), 1'b0);
        chk("seven_level", fifo_level, 7);
        chk("seven_event", event_cnt, 7);
        rst_n = 1'b0;
        tick();
        chk("midrst_disc", disc, 0);
        chk("midrst_halt", halt, 1);
        chk("midrst_run", run, 0);
        chk("midrst_rd_valid", rd_if.rd_valid, 0);
        chk("midrst_rd_data", rd_if.rd_data, 0);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_event", event_cnt, 0);
        chk("midrst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        tick();

`ifdef PULSE_PEAK_FILTER_EN
        cfg_peak_min = 8'h40;
        start(8'h10);
        wait_halt_low(n);
        chk("filt_halt_cycles", n, 5);
        rd_if.rd_ready = 1'b1;
        pulse(mk(8'h10, 500), 1'b0);
        chk("filt_reject", reject_cnt, 1);
        chk("filt_reject_event", event_cnt, 0);
        chk("filt_reject_level", fifo_level, 0);
        pulse(mk(8'h80, 501), 1'b1);
        chk("filt_pass_event", event_cnt, 1);
        chk("filt_pass_valid", rd_if.rd_valid, 1);
        rd_if.rd_ready = 1'b1;
`endif

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
